// File: rtl/gb_sprite_pkg.sv
// gb_sprite_pkg: shared sprite-scan limits, scan FSM states and the per-line Y range test
package gb_sprite_pkg;
   localparam int MAX_SPR     = 10;
   localparam int OAM_ENTRIES = 40;
   localparam int Y_OFFSET    = 16;
   typedef enum logic [2:0] {IDLE, SCAN_ADDR, SCAN_EVAL, FETCH_LO, FETCH_HI, DONE} scan_state_e;
   function automatic logic spr_on_line(input logic [7:0] y, input logic [7:0] v, input logic tall);
      logic [8:0] line;
      logic [8:0] top;
      line = {1'b0, v} + 9'(Y_OFFSET);
      top  = {1'b0, y};
      return (line >= top) && (line < top + (tall ? 9'd16 : 9'd8));
   endfunction
endpackage

// File: rtl/sprite_slot_list.sv
// sprite_slot_list: per-line list of selected OAM indices, one write port and two read ports
module sprite_slot_list #(
   parameter int N_SLOTS = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       wr_en,
   input  logic [3:0] wr_slot,
   input  logic [5:0] wr_idx,
   input  logic [3:0] rd_slot_a,
   output logic [5:0] rd_idx_a,
   input  logic [3:0] rd_slot_b,
   output logic [5:0] rd_idx_b
);
   logic [5:0] list_q [N_SLOTS];
   logic [5:0] list_d [N_SLOTS];
   always_comb begin
      list_d   = list_q;
      rd_idx_a = 6'd0;
      rd_idx_b = 6'd0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (wr_en && wr_slot == 4'(i)) list_d[i] = wr_idx;
         if (rd_slot_a == 4'(i)) rd_idx_a = list_q[i];
         if (rd_slot_b == 4'(i)) rd_idx_b = list_q[i];
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_SLOTS; i++) list_q[i] <= 6'd0;
      end else begin
         list_q <= list_d;
      end
   end
endmodule

// File: rtl/oam_scan_fetch.sv
// oam_scan_fetch: per-line OAM Y scan selecting up to MAX_SPR sprites, then a two-plane tile fetch per sprite
module oam_scan_fetch #(
   parameter int MAX_SPR     = gb_sprite_pkg::MAX_SPR,
   parameter int OAM_ENTRIES = gb_sprite_pkg::OAM_ENTRIES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       line_start,
   input  logic [7:0] v_cnt,
   input  logic       size16,
   output logic [7:0] oam_rd_addr,
   input  logic [7:0] oam_rd_data,
   output logic       vram_req,
   input  logic       vram_ack,
   output logic [5:0] spr_idx,
   output logic [1:0] ds,
   output logic       busy,
   output logic       done,
   output logic [3:0] count,
   input  logic [3:0] list_slot,
   output logic [5:0] list_idx
);
   import gb_sprite_pkg::*;
   localparam logic [3:0] MAX_CNT = 4'(MAX_SPR);
   localparam logic [5:0] LAST_N  = 6'(OAM_ENTRIES - 1);
   scan_state_e state_q, state_d;
   logic [5:0] n_q, n_d;
   logic [3:0] k_q, k_d, count_q, count_d;
   logic [7:0] oam_rd_addr_q, oam_rd_addr_d;
   logic       vram_req_q, vram_req_d, busy_q, busy_d, done_q, done_d;
   logic       wr_en, hit, fetching;
   logic [5:0] fetch_idx, slot_idx;
   sprite_slot_list #(.N_SLOTS(MAX_SPR)) u_list (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (wr_en),
      .wr_slot   (count_q),
      .wr_idx    (n_q),
      .rd_slot_a (k_q),
      .rd_idx_a  (fetch_idx),
      .rd_slot_b (list_slot),
      .rd_idx_b  (slot_idx)
   );
   always_comb begin
      hit     = spr_on_line(oam_rd_data, v_cnt, size16);
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      count_d = count_q;
      wr_en   = 1'b0;
      if (line_start) begin
         state_d = SCAN_ADDR;
         n_d     = 6'd0;
         count_d = 4'd0;
      end else begin
         case (state_q)
            SCAN_ADDR: state_d = SCAN_EVAL;
            SCAN_EVAL: begin
               // once the list is full, later hits are dropped so the lowest indices win
               wr_en   = hit && (count_q < MAX_CNT);
               count_d = count_q + {3'd0, wr_en};
               n_d     = (n_q == LAST_N) ? n_q : n_q + 6'd1;
               k_d     = 4'd0;
               state_d = (n_q != LAST_N) ? SCAN_ADDR : (count_d != 4'd0) ? FETCH_LO : DONE;
            end
            FETCH_LO: state_d = vram_ack ? FETCH_HI : FETCH_LO;
            FETCH_HI: begin
               k_d     = (vram_ack && k_q != count_q - 4'd1) ? k_q + 4'd1 : k_q;
               state_d = !vram_ack ? FETCH_HI : (k_q == count_q - 4'd1) ? DONE : FETCH_LO;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      oam_rd_addr_d = (state_d == SCAN_ADDR) ? {n_d, 2'b00} : 8'd0;
      vram_req_d    = (state_d == FETCH_LO) || (state_d == FETCH_HI);
      busy_d        = state_d != IDLE;
      done_d        = state_d == DONE;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         n_q           <= 6'd0;
         k_q           <= 4'd0;
         count_q       <= 4'd0;
         oam_rd_addr_q <= 8'd0;
         vram_req_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         k_q           <= k_d;
         count_q       <= count_d;
         oam_rd_addr_q <= oam_rd_addr_d;
         vram_req_q    <= vram_req_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end
   // a restart pulse wins over a coincident ack, so no plane strobe leaks out
   assign fetching    = (state_q == FETCH_LO) || (state_q == FETCH_HI);
   assign ds          = (!vram_ack || line_start) ? 2'b00 :
                        (state_q == FETCH_LO) ? 2'b01 : (state_q == FETCH_HI) ? 2'b10 : 2'b00;
   assign spr_idx     = fetching ? fetch_idx : 6'd0;
   assign list_idx    = (list_slot < count_q) ? slot_idx : 6'd0;
   assign oam_rd_addr = oam_rd_addr_q;
   assign vram_req    = vram_req_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign count       = count_q;
endmodule
